// File: rtl/gpio_irq.sv
// Pin conditioning for the GPIO block: 2-flop sync, per-pin debounce, edge detect into W1C status, level irq.
// Registers: IN (RO), EDGE_EN (RW), STATUS (W1C), DB_LIMIT (RW) at BASE+0x0/0x4/0x8/0xC; reads are combinational.
module gpio_irq #(
    parameter int          WIDTH     = 8,
    parameter logic [31:0] BASE_ADDR = 32'hFFFF0018,
    parameter int          DB_W      = 16,
    parameter int unsigned DB_RESET  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      address,
    input  logic [31:0]      write_data,
    input  logic             write_enable,
    output logic [31:0]      read_data,
    input  logic [WIDTH-1:0] pins_in,
    output logic             irq
);

    localparam int EW = 2 * WIDTH;

    logic [WIDTH-1:0] s1_q, s2_q;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [DB_W-1:0]  cnt_q [WIDTH];
    logic [DB_W-1:0]  cnt_d [WIDTH];
    logic [EW-1:0]    edge_en_q, edge_en_d;
    logic [EW-1:0]    status_q, status_d;
    logic [DB_W-1:0]  db_limit_q, db_limit_d;

    logic sel_in, sel_en, sel_st, sel_db;
    logic [WIDTH-1:0] rise_ev, fall_ev;
    logic [EW-1:0]    set_vec, clr_vec;
    logic             unused_wdata;

    assign sel_in = (address == BASE_ADDR);
    assign sel_en = (address == BASE_ADDR + 32'h4);
    assign sel_st = (address == BASE_ADDR + 32'h8);
    assign sel_db = (address == BASE_ADDR + 32'hC);

    assign unused_wdata = ^write_data;

    // Debounce: a mismatch must persist past DB_LIMIT counted cycles before stable follows s2.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            stable_d[i] = stable_q[i];
            cnt_d[i]    = cnt_q[i];
            if (s2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= db_limit_q) begin
                stable_d[i] = s2_q[i];
                cnt_d[i]    = '0;
            end else if (cnt_q[i] != {DB_W{1'b1}}) begin
                cnt_d[i] = cnt_q[i] + DB_W'(1);
            end
        end
    end

    assign rise_ev = stable_d & ~stable_q;
    assign fall_ev = ~stable_d & stable_q;
    assign set_vec = {fall_ev & edge_en_q[EW-1:WIDTH], rise_ev & edge_en_q[WIDTH-1:0]};
    assign clr_vec = (write_enable && sel_st) ? write_data[EW-1:0] : '0;

    // Hardware set is OR'ed in after the clear so a coincident event wins.
    always_comb begin
        status_d   = (status_q & ~clr_vec) | set_vec;
        edge_en_d  = edge_en_q;
        db_limit_d = db_limit_q;
        if (write_enable && sel_en) begin
            edge_en_d = write_data[EW-1:0];
        end
        if (write_enable && sel_db) begin
            db_limit_d = write_data[DB_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q       <= '0;
            s2_q       <= '0;
            stable_q   <= '0;
            edge_en_q  <= '0;
            status_q   <= '0;
            db_limit_q <= DB_W'(DB_RESET);
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q       <= pins_in;
            s2_q       <= s1_q;
            stable_q   <= stable_d;
            edge_en_q  <= edge_en_d;
            status_q   <= status_d;
            db_limit_q <= db_limit_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        read_data = '0;
        if (sel_in) begin
            read_data[WIDTH-1:0] = stable_q;
        end else if (sel_en) begin
            read_data[EW-1:0] = edge_en_q;
        end else if (sel_st) begin
            read_data[EW-1:0] = status_q;
        end else if (sel_db) begin
            read_data[DB_W-1:0] = db_limit_q;
        end
    end

    assign irq = |status_q;

endmodule

// File: tb/tb_gpio_irq.sv
// Directed bench for gpio_irq; reads push expectations into a scoreboard that a negedge monitor drains.
module tb_gpio_irq;

    localparam logic [31:0] A_IN = 32'hFFFF0018;
    localparam logic [31:0] A_EN = 32'hFFFF001C;
    localparam logic [31:0] A_ST = 32'hFFFF0020;
    localparam logic [31:0] A_DB = 32'hFFFF0024;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        write_enable;
    logic [31:0] read_data;
    logic [7:0]  pins_in;
    logic        irq;

    logic        chk_vld;
    logic [31:0] exp_d [$];
    logic        exp_i [$];
    string       exp_n [$];
    int          checks = 0;
    int          errors = 0;

    gpio_irq dut (
        .clk          (clk),
        .rst          (rst),
        .address      (address),
        .write_data   (write_data),
        .write_enable (write_enable),
        .read_data    (read_data),
        .pins_in      (pins_in),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        logic [31:0] ed;
        logic        ei;
        string       nm;
        if (chk_vld) begin
            if (exp_d.size() == 0) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL scoreboard_underflow read_data=%h", read_data);
            end else begin
                ed = exp_d.pop_front();
                ei = exp_i.pop_front();
                nm = exp_n.pop_front();
                checks = checks + 1;
                if (read_data !== ed) begin
                    errors = errors + 1;
                    $display("FAIL %s read_data got %h expected %h", nm, read_data, ed);
                end
                checks = checks + 1;
                if (irq !== ei) begin
                    errors = errors + 1;
                    $display("FAIL %s irq got %b expected %b", nm, irq, ei);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] ed, input logic ei, input string nm);
        address = a;
        exp_d.push_back(ed);
        exp_i.push_back(ei);
        exp_n.push_back(nm);
        chk_vld = 1'b1;
        tick();
        chk_vld = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        address      = a;
        write_data   = d;
        write_enable = 1'b1;
        tick();
        write_enable = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        address      = '0;
        write_data   = '0;
        write_enable = 1'b0;
        pins_in      = 8'h00;
        chk_vld      = 1'b0;
        ticks(2);
        rst = 1'b0;

        // Reset state
        rd(A_IN, 32'h0, 1'b0, "rst_in");
        rd(A_EN, 32'h0, 1'b0, "rst_en");
        rd(A_ST, 32'h0, 1'b0, "rst_st");
        rd(A_DB, 32'h4, 1'b0, "rst_db");

        // Rise on pin 0 with DB_LIMIT=4 commits at posedge 7
        wr(A_EN, 32'h0000_00FF);
        pins_in = 8'h01;
        ticks(6);
        rd(A_IN, 32'h0, 1'b0, "rise_in_p6");
        rd(A_IN, 32'h1, 1'b1, "rise_in_p7");
        rd(A_ST, 32'h1, 1'b1, "rise_st");
        ticks(10);
        wr(A_ST, 32'h1);
        rd(A_ST, 32'h0, 1'b0, "rise_w1c");

        // Glitch of exactly DB_LIMIT cycles is rejected; longer low commits a fall
        wr(A_DB, 32'h4);
        wr(A_EN, 32'h0000_FF00);
        pins_in = 8'h09;
        ticks(12);
        rd(A_IN, 32'h09, 1'b0, "glitch_pre_in");
        rd(A_ST, 32'h0, 1'b0, "rise_disabled_st");
        pins_in = 8'h01;
        ticks(4);
        pins_in = 8'h09;
        ticks(12);
        rd(A_IN, 32'h09, 1'b0, "glitch_in");
        rd(A_ST, 32'h0, 1'b0, "glitch_st");
        pins_in = 8'h01;
        ticks(12);
        rd(A_ST, 32'h0800, 1'b1, "fall_st");
        rd(A_IN, 32'h01, 1'b1, "fall_in");
        wr(A_ST, 32'hFFFF_FFFF);
        rd(A_ST, 32'h0, 1'b0, "fall_w1c");

        // DB_LIMIT=0: each edge commits three cycles after the pin change
        wr(A_DB, 32'h0);
        wr(A_EN, 32'hFFFF_FFFF);
        rd(A_EN, 32'h0000_FFFF, 1'b0, "en_upper_zero");
        pins_in = 8'h81;
        ticks(2);
        rd(A_ST, 32'h0, 1'b0, "db0_rise_p2");
        rd(A_ST, 32'h80, 1'b1, "db0_rise_p3");
        tick();
        pins_in = 8'h01;
        ticks(2);
        rd(A_ST, 32'h80, 1'b1, "db0_fall_p2");
        rd(A_ST, 32'h8080, 1'b1, "db0_fall_p3");
        rd(A_IN, 32'h01, 1'b1, "db0_in");
        wr(A_ST, 32'hFFFF);
        rd(A_ST, 32'h0, 1'b0, "db0_w1c");

        // Hardware set beats a coincident W1C; writing 0 leaves other bits alone
        pins_in = 8'h00;
        ticks(6);
        rd(A_ST, 32'h0100, 1'b1, "pre_race_st");
        pins_in = 8'h01;
        ticks(2);
        wr(A_ST, 32'h1);
        rd(A_ST, 32'h0101, 1'b1, "race_st");
        wr(A_ST, 32'hFFFF);
        rd(A_ST, 32'h0, 1'b0, "race_w1c");

        // Late enable is not retroactive; unmapped addresses
        wr(A_EN, 32'h0);
        pins_in = 8'h05;
        ticks(6);
        rd(A_IN, 32'h05, 1'b0, "noen_in");
        wr(A_EN, 32'hFF);
        rd(A_ST, 32'h0, 1'b0, "late_en_st");
        rd(32'hFFFF_0028, 32'h0, 1'b0, "unmapped_rd");
        wr(32'h0000_000C, 32'h7);
        rd(A_DB, 32'h0, 1'b0, "partial_addr_wr");
        wr(32'hFFFF_0028, 32'hFFFF);
        rd(A_EN, 32'hFF, 1'b0, "unmapped_wr");

        // Reset mid-debounce clears everything at once
        pins_in = 8'h07;
        ticks(4);
        rd(A_ST, 32'h02, 1'b1, "pre_rst_st");
        wr(A_DB, 32'd10);
        pins_in = 8'hFF;
        ticks(5);
        rst = 1'b1;
        rd(A_IN, 32'h0, 1'b0, "midrst_in");
        rd(A_ST, 32'h0, 1'b0, "midrst_st");
        rd(A_DB, 32'h4, 1'b0, "midrst_db");
        rd(A_EN, 32'h0, 1'b0, "midrst_en");
        rst = 1'b0;
        ticks(12);
        rd(A_IN, 32'hFF, 1'b0, "post_rst_in");
        rd(A_ST, 32'h0, 1'b0, "post_rst_st");

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_irq.md
# gpio_irq

Input-conditioning and edge-interrupt stage for the GPIO pins. Samples the 8 pin levels the `gpio` block exposes, synchronizes and debounces them, and detects per-pin rising and falling edges. Edge events latch into a write-1-to-clear status register and drive a level interrupt to the core. It is a memory-mapped peripheral on the same CPU data bus as `gpio`, decoded directly above it.

## Interface
- `WIDTH`, 8: number of pins conditioned.
- `BASE_ADDR`, 32'hFFFF0018: address of register 0; registers are at BASE+0x0/0x4/0x8/0xC.
- `DB_W`, 16: width of the debounce counter and the limit register.
- `DB_RESET`, 4: reset value of the debounce limit.

Ports:
- `clk` in 1: core clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `address` in 32: bus byte address.
- `write_data` in 32: bus write data.
- `write_enable` in 1: write strobe, one cycle per write, sampled at posedge.
- `read_data` out 32: combinational read of the addressed register; 0 for unmapped addresses.
- `pins_in` in WIDTH: raw pin levels, asynchronous to `clk`.
- `irq` out 1: level interrupt, `|status`.

## Operation
Registers:
- BASE+0x0 IN (RO): debounced levels `stable[WIDTH-1:0]`; upper bits read 0; writes ignored.
- BASE+0x4 EDGE_EN (RW): [7:0] rise enable, [15:8] fall enable; other bits read 0.
- BASE+0x8 STATUS (W1C): [7:0] rise seen, [15:8] fall seen; writing 1 clears a bit, writing 0 leaves it unchanged.
- BASE+0xC DB_LIMIT (RW): low DB_W bits.

Per-pin datapath:
- Two-flop synchronizer: `pins_in` -> `s1` -> `s2`.
- Debounce: if `s2 == stable`, `cnt <= 0`. If `s2 != stable` and `cnt >= DB_LIMIT`, then `stable <= s2` and `cnt <= 0`. Otherwise `cnt <= cnt + 1`, saturating at all-ones.
- Edge event: generated in the cycle `stable` updates. A rise is 0->1 and a fall is 1->0. The matching STATUS bit is set only if its EDGE_EN bit is 1 in that cycle.
- Enabling an edge later never retroactively sets STATUS. Disabling an edge does not clear STATUS bits that are already set.
- Simultaneous hardware set and W1C on the same bit: the set wins and the bit stays 1.
- A DB_LIMIT write takes effect from the next cycle. The `>=` compare means a counter already past the new limit commits on its next mismatch cycle.
- Address decode matches the full 32-bit word. Unmapped writes have no effect.

## Timing
- Reset (async assert): `s1`, `s2`, `stable`, `cnt`, EDGE_EN and STATUS clear to 0; DB_LIMIT = DB_RESET; `irq` = 0; `read_data` reads 0 for IN, EDGE_EN and STATUS.
- Reset release with pins high: `stable` rises after debounce, but no STATUS bit sets because EDGE_EN = 0.
- Latency: a pin change stable from before posedge 1 reaches `s2` at posedge 2. `stable` and STATUS update at posedge 3+DB_LIMIT. `irq` rises combinationally after that edge.
- Glitch rejection: a pin change whose `s2` mismatch lasts ≤ DB_LIMIT cycles is rejected; `cnt` returns to 0 and `stable` does not change.
- DB_LIMIT = 0: `stable` follows `s2` with one cycle of delay.
- Write commit: register writes take effect at the posedge where `write_enable` is 1, and are visible on `read_data` afterwards.
- Reset mid-count: asserting `rst` discards all debounce progress and pending STATUS immediately.

## Test plan
- Reset with `pins_in`=8'h00: IN, EDGE_EN and STATUS read 0, DB_LIMIT reads 4, `irq`=0.
- Set EDGE_EN=32'h000000FF, then drive `pins_in`=8'h01 for 20 cycles. IN=1 and STATUS=32'h1 from exactly posedge 7 after the change, `irq`=1. Write STATUS=1: STATUS=0, `irq`=0.
- DB_LIMIT=4, EDGE_EN=32'hFF00, pin 3 high then pulsed low for 4 cycles: IN bit3 stays 1 and STATUS=0. Hold low for 10 cycles: STATUS=32'h0800.
- DB_LIMIT=0, EDGE_EN=32'hFFFF, toggle pin 7 0->1->0 with 5 cycles between changes: STATUS=32'h8080. Check latency of 3 cycles per edge.
- A rising edge commits in the same cycle as a W1C write of bit0: bit0 remains 1 and `irq` stays 1.
- Enables off, pin 2 rises, then EDGE_EN=32'hFF: STATUS stays 0. Read of 32'hFFFF0028 returns 0. Asserting `rst` mid-debounce clears IN and STATUS immediately.
